// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: instruction formats, base opcodes and the decoded packet.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_ILLEGAL = 3'd6
  } instr_fmt_e;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;

  typedef struct packed {
    logic [31:0]     idata;
    logic [XLEN-1:0] rv1;
    logic [XLEN-1:0] rv2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    instr_fmt_e      fmt;
  } decoded_pkt_t;

endpackage

// File: rtl/rv32i_decode_stage_regfile.sv
// Architectural register file: two combinational reads, one synchronous write, x0 tied to zero.
module rv32i_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  output logic [XLEN-1:0]          rdata1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [XLEN-1:0]          rdata2,
  input  logic                     wen,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata
);

  logic [NREGS-1:0][XLEN-1:0] regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (wen && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 is never written, so its storage stays zero from reset
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/rv32i_decode_stage.sv
// Single-stage RV32I decode: regfile read with writeback bypass, immediate build, registered packet.
module rv32i_decode_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_idata,
  output logic [XLEN-1:0] out_rv1,
  output logic [XLEN-1:0] out_rv2,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_fmt,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rf_rv1, rf_rv2;
  logic            accept;
  instr_fmt_e      fmt;
  decoded_pkt_t    pkt_d, pkt_q;
  logic            vld_q;

  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];

  rv32i_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1),
    .rdata1 (rf_rv1),
    .raddr2 (rs2),
    .rdata2 (rf_rv2),
    .wen    (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    fmt = FMT_ILLEGAL;
    case (in_instr[6:0])
      OP:                  fmt = FMT_R;
      OP_IMM, LOAD, JALR:  fmt = FMT_I;
      STORE:               fmt = FMT_S;
      BRANCH:              fmt = FMT_B;
      LUI, AUIPC:          fmt = FMT_U;
      JAL:                 fmt = FMT_J;
      default:             fmt = FMT_ILLEGAL;
    endcase
  end

  always_comb begin
    pkt_d       = '0;
    pkt_d.idata = in_instr;
    pkt_d.rd    = in_instr[11:7];
    pkt_d.fmt   = fmt;
    // same-cycle writeback wins over the stale regfile value
    pkt_d.rv1 = (wb_en && wb_addr != 5'd0 && wb_addr == rs1) ? wb_data : rf_rv1;
    pkt_d.rv2 = (wb_en && wb_addr != 5'd0 && wb_addr == rs2) ? wb_data : rf_rv2;
    case (fmt)
      FMT_I: pkt_d.imm = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: pkt_d.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: pkt_d.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: pkt_d.imm = {in_instr[31:12], 12'b0};
      FMT_J: pkt_d.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: pkt_d.imm = '0;
    endcase
    if (fmt == FMT_ILLEGAL) begin
      pkt_d.rv1 = '0;
      pkt_d.rv2 = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      pkt_q <= '0;
    end else if (accept) begin
      vld_q <= 1'b1;
      pkt_q <= pkt_d;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign out_idata = pkt_q.idata;
  assign out_rv1   = pkt_q.rv1;
  assign out_rv2   = pkt_q.rv2;
  assign out_imm   = pkt_q.imm;
  assign out_rd    = pkt_q.rd;
  assign out_fmt   = pkt_q.fmt;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Randomized + directed bench for rv32i_decode_stage against an arithmetic reference model.
module tb_rv32i_decode_stage;
  import riscv_pkg::*;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_idata, out_rv1, out_rv2, out_imm, wb_data;
  logic [4:0]  out_rd, wb_addr;
  logic [2:0]  out_fmt;
  logic        wb_en;

  rv32i_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_idata(out_idata), .out_rv1(out_rv1), .out_rv2(out_rv2),
    .out_imm(out_imm), .out_rd(out_rd), .out_fmt(out_fmt),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  logic [31:0] mregs [32];
  logic        e_valid;
  logic [31:0] e_idata, e_rv1, e_rv2, e_imm;
  logic [4:0]  e_rd;
  logic [2:0]  e_fmt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
    case (ins[6:0])
      7'h33:               return 3'd0;
      7'h13, 7'h03, 7'h67: return 3'd1;
      7'h23:               return 3'd2;
      7'h63:               return 3'd3;
      7'h37, 7'h17:        return 3'd4;
      7'h6F:               return 3'd5;
      default:             return 3'd6;
    endcase
  endfunction

  // immediates from arithmetic shifts and masks, not field concatenation
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [31:0] s20, s19, s11;
    s20 = 32'($signed(ins) >>> 20);
    s19 = 32'($signed(ins) >>> 19);
    s11 = 32'($signed(ins) >>> 11);
    case (ref_fmt(ins))
      3'd1: return s20;
      3'd2: return (s20 & 32'hFFFF_FFE0) | ((ins >> 7) & 32'h1F);
      3'd3: return (s19 & 32'hFFFF_F000) | (((ins >> 7) & 1) << 11)
                 | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
      3'd4: return ins & 32'hFFFF_F000;
      3'd5: return (s11 & 32'hFFF0_0000) | (ins & 32'h000F_F000)
                 | (((ins >> 20) & 1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return mregs[a];
  endfunction

  task automatic model_reset();
    foreach (mregs[i]) mregs[i] = 32'h0;
    e_valid = 0; e_idata = 0; e_rv1 = 0; e_rv2 = 0; e_imm = 0; e_rd = 0; e_fmt = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    if (e_valid) begin
      chk({tag, ".idata"}, out_idata, e_idata);
      chk({tag, ".rv1"},   out_rv1,   e_rv1);
      chk({tag, ".rv2"},   out_rv2,   e_rv2);
      chk({tag, ".imm"},   out_imm,   e_imm);
      chk({tag, ".rd"},    32'(out_rd),  32'(e_rd));
      chk({tag, ".fmt"},   32'(out_fmt), 32'(e_fmt));
    end
  endtask

  // one clock: drive at posedge+1, check ready, update model, then check registered outputs
  task automatic cyc(input string tag, input logic v, input logic [31:0] ins, input logic rdy,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic acc;
    in_valid = v; in_instr = ins; out_ready = rdy; wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!e_valid || rdy));
    acc = v && (!e_valid || rdy);
    if (acc) begin
      e_valid = 1; e_idata = ins; e_rd = ins[11:7];
      e_fmt = ref_fmt(ins); e_imm = ref_imm(ins);
      e_rv1 = (e_fmt == 3'd6) ? 32'h0 : ref_read(ins[19:15], we, wa, wd);
      e_rv2 = (e_fmt == 3'd6) ? 32'h0 : ref_read(ins[24:20], we, wa, wd);
    end else if (rdy) e_valid = 0;
    if (we && wa != 0) mregs[wa] = wd;
    @(posedge clk); #1;
    check_outs(tag);
  endtask

  logic [6:0] ops [10];

  initial begin
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    model_reset();
    rst_n = 0; in_valid = 0; in_instr = 0; out_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    #12;
    check_outs("reset");
    chk("reset.idata", out_idata, 32'h0);
    chk("reset.imm", out_imm, 32'h0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // T1: preload x1=5, then addi x1,x1,-1
    cyc("t1.pre", 0, 0, 1, 1, 5'd1, 32'd5);
    cyc("t1", 1, 32'hFFF0_8093, 1, 0, 0, 0);
    chk("t1.imm_const", out_imm, 32'hFFFF_FFFF);
    chk("t1.rv1_const", out_rv1, 32'd5);
    chk("t1.fmt_const", 32'(out_fmt), 32'(FMT_I));

    // T2: srai x2,x3,5 with x3=0x80000000
    cyc("t2.pre", 0, 0, 1, 1, 5'd3, 32'h8000_0000);
    cyc("t2", 1, 32'h4051_D113, 1, 0, 0, 0);
    chk("t2.imm_const", out_imm, 32'h0000_0405);
    chk("t2.idata30", 32'(out_idata[30]), 32'd1);
    chk("t2.rv1_const", out_rv1, 32'h8000_0000);

    // T3: write to x0 ignored
    cyc("t3.pre", 0, 0, 1, 1, 5'd0, 32'hDEAD);
    cyc("t3", 1, 32'h0000_0093, 1, 0, 0, 0);
    chk("t3.rv1_const", out_rv1, 32'h0);

    // T4: same-cycle bypass of x1
    cyc("t4", 1, 32'hFFF0_8093, 1, 1, 5'd1, 32'h1234);
    chk("t4.rv1_const", out_rv1, 32'h1234);

    // T5: stall three cycles, writeback during stall must not refresh the held packet
    cyc("t5.issue", 1, 32'h0020_8133, 0, 0, 0, 0);
    cyc("t5.stall0", 1, 32'h0031_0193, 0, 1, 5'd1, 32'h7777);
    cyc("t5.stall1", 1, 32'h0031_0193, 0, 0, 0, 0);
    cyc("t5.stall2", 1, 32'h0031_0193, 0, 0, 0, 0);
    cyc("t5.release", 1, 32'h0031_0193, 1, 0, 0, 0);
    chk("t5.next_idata", out_idata, 32'h0031_0193);

    // T6: illegal opcode still issues with zeroed operands
    cyc("t6", 1, 32'h0000_007F, 1, 0, 0, 0);
    chk("t6.fmt_const", 32'(out_fmt), 32'(FMT_ILLEGAL));
    chk("t6.imm_const", out_imm, 32'h0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      cyc("rand", ($urandom_range(0, 3) != 0), ins, ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 31)), $urandom);
    end

    // T6b: reset during a stall drops the packet and clears the regfile
    cyc("t6b.issue", 1, 32'h0000_8093, 0, 0, 0, 0);
    cyc("t6b.stall", 1, 32'h0000_8093, 0, 0, 0, 0);
    rst_n = 0; #1;
    chk("t6b.valid_async", 32'(out_valid), 32'd0);
    chk("t6b.idata_async", out_idata, 32'h0);
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    for (int r = 1; r < 32; r++) begin
      logic [31:0] ins;
      ins = {12'h000, 5'(r), 3'b000, 5'(r), 7'h13};
      cyc("t6b.regzero", 1, ins, 1, 0, 0, 0);
      chk("t6b.rv1_const", out_rv1, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1);
  end

endmodule
